bandit_environment: RTL and testbench
=====================================

# bandit_environment

Simulated multi-armed bandit environment that closes the loop around the bandit agent. It accepts one 8-bit action (arm index) per handshake and looks up that arm's programmed mean reward. It adds pseudo-random noise from an LFSR and returns a saturated 16-bit signed reward over a valid/ready channel. Arm means are loaded through a simple write port, so benches and on-chip tests can build deterministic or noisy reward landscapes.

## Interface

Parameters:
- NOISE_ENABLE, 1: when 0, the noise term is forced to 0.
- NOISE_SHIFT, 4: arithmetic right shift applied to the LFSR value to form the noise term. Legal range 0..15.
- SEED, 16'hACE1: LFSR value loaded on reset. 0 is illegal; if SEED is 0, the LFSR loads 16'h0001 instead.

Ports:
- clock  in  1  clock, rising-edge.
- reset  in  1  reset, synchronous, active-high.
- action_valid  in  1  agent presents an action.
- action_data  in  8  arm index.
- action_ready  out  1  environment can accept an action.
- reward_valid  out  1  reward available.
- reward_data  out  16  signed reward.
- reward_ready  in  1  agent accepts the reward.
- cfg_valid  in  1  write strobe for the arm-mean table.
- cfg_addr  in  8  arm index to write.
- cfg_data  in  16  signed mean for that arm.
- cfg_ready  out  1  table write is accepted this cycle.
- pulls  out  32  count of completed reward handshakes.

## Operation

- Arm table: 256 x 16-bit signed entries, initialised to 0 at configuration.
  - Reset does not clear the table.
  - A write occurs on any edge with cfg_valid & cfg_ready.
- State machine states: IDLE, LOOKUP, COMPUTE, RESPOND.
  - IDLE: action_ready=1, cfg_ready=1. On action_valid, the block latches action_data, captures the current LFSR value as noise source, advances the LFSR one step, and goes to LOOKUP.
  - LOOKUP: registered table read at the latched index; goes to COMPUTE.
  - COMPUTE: sum = sext17(mean) + sext17(noise). reward_data <= sat16(sum), clamped to [-32768, 32767]. reward_valid <= 1. Goes to RESPOND.
  - RESPOND: reward_valid=1; reward_data is held stable. On reward_ready: reward_valid <= 0, pulls <= pulls+1, go to IDLE.
- Noise: noise = NOISE_ENABLE ? ($signed(lfsr) >>> NOISE_SHIFT) : 0.
- LFSR: 16-bit Galois, right shift, lfsr <= (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 0).
  - It advances only on action acceptance, never otherwise.
- Simultaneous cfg write and action accept in IDLE: both occur. If the addresses are equal, the LOOKUP read returns the newly written value.
- cfg_ready=0 outside IDLE. Writes presented then are not taken; the writer must hold them until cfg_ready.
- pulls wraps from 2^32-1 to 0.

## Timing

- Reset values: action_ready=1, cfg_ready=1, reward_valid=0, reward_data=0, pulls=0, state=IDLE, lfsr=SEED.
- Latency: action accepted on edge E0. reward_valid is high after E2, two edges later.
- The earliest next action acceptance is one edge after the reward handshake edge.
- action_ready and cfg_ready are combinational decodes of state==IDLE and do not depend on any input.
- reward_valid never drops without a handshake except on reset.
- Reset asserted in any state: at the next edge the block returns to its reset values and any in-flight action is discarded. The table is retained.
- Throughput: one action per 4 cycles minimum when reward_ready is held high.

## Test plan

- NOISE_ENABLE=0: write arm 5 = 1000, then send action 5. Required response:
  - reward_valid rises two edges after acceptance with reward_data=1000.
  - pulls=1 after the handshake.
- NOISE_ENABLE=1, NOISE_SHIFT=0, SEED=16'h7FFF, arm 7 = 32767, action 7: reward_data=32767 (positive saturation).
  - Repeat the check with SEED=16'h8000 and arm 7 = -32768: reward_data=-32768.
- LFSR sequence, SEED=16'hACE1: after one accepted action lfsr=16'hE270.
  - With SEED=16'h0001, after one accepted action lfsr=16'hB400.
  - The LFSR is unchanged across idle cycles.
- Backpressure: hold reward_ready=0 for 5 cycles in RESPOND. Required response:
  - reward_valid and reward_data stay constant.
  - action_ready=0 and cfg_ready=0.
  - A cfg write attempted in this window does not modify the table.
- Same-cycle cfg write to arm 3 = -200 and action 3 in IDLE, NOISE_ENABLE=0: reward_data=-200.
- Reset asserted during COMPUTE: after the reset edge, reward_valid=0, action_ready=1, pulls=0, lfsr=SEED. A subsequent action still returns the previously programmed mean.

Source files
------------

// File: rtl/bandit_environment.sv
// Simulated multi-armed bandit: takes an arm index, returns the arm's programmed
// mean plus LFSR noise as a saturated signed 16-bit reward over valid/ready.
module bandit_environment #(
  parameter bit          NOISE_ENABLE = 1'b1,
  parameter int          NOISE_SHIFT  = 4,
  parameter logic [15:0] SEED         = 16'hACE1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        action_valid,
  input  logic [7:0]  action_data,
  output logic        action_ready,
  output logic        reward_valid,
  output logic [15:0] reward_data,
  input  logic        reward_ready,
  input  logic        cfg_valid,
  input  logic [7:0]  cfg_addr,
  input  logic [15:0] cfg_data,
  output logic        cfg_ready,
  output logic [31:0] pulls
);

  typedef enum logic [1:0] {IDLE, LOOKUP, COMPUTE, RESPOND} state_t;

  // An all-zero Galois LFSR locks up, so a zero seed is promoted to 1.
  localparam logic [15:0] LFSR_INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;

  state_t             state;
  logic [15:0]        lfsr;
  logic [15:0]        noise_src;
  logic [15:0]        mean_q;
  logic [7:0]         arm_idx;
  logic [15:0]        arm_mean [256] = '{default: 16'h0000};
  logic signed [15:0] noise;
  logic signed [16:0] sum;
  logic [15:0]        sat;
  logic [15:0]        lfsr_next;

  assign action_ready = (state == IDLE);
  assign cfg_ready    = (state == IDLE);

  assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  assign noise     = NOISE_ENABLE ? ($signed(noise_src) >>> NOISE_SHIFT) : 16'sh0000;
  assign sum       = $signed({mean_q[15], mean_q}) + $signed({noise[15], noise});

  always_comb begin
    sat = sum[15:0];
    if (sum[16:15] == 2'b01)      sat = 16'h7FFF;
    else if (sum[16:15] == 2'b10) sat = 16'h8000;
  end

  // Table is deliberately outside reset so programmed landscapes survive it.
  // A same-edge write to the accepted arm lands before the LOOKUP read.
  always_ff @(posedge clock) begin
    if (cfg_valid && cfg_ready) arm_mean[cfg_addr] <= cfg_data;
    if (state == LOOKUP)        mean_q <= arm_mean[arm_idx];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      lfsr         <= LFSR_INIT;
      reward_valid <= 1'b0;
      reward_data  <= 16'h0000;
      pulls        <= 32'd0;
    end else begin
      case (state)
        IDLE: if (action_valid) begin
          arm_idx   <= action_data;
          noise_src <= lfsr;
          lfsr      <= lfsr_next;
          state     <= LOOKUP;
        end
        LOOKUP: state <= COMPUTE;
        COMPUTE: begin
          reward_data  <= sat;
          reward_valid <= 1'b1;
          state        <= RESPOND;
        end
        RESPOND: if (reward_ready) begin
          reward_valid <= 1'b0;
          pulls        <= pulls + 32'd1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bandit_environment.sv
// Bench for bandit_environment: several parameterisations side by side, directed
// scenarios plus a randomized run checked against an arithmetic reference model.
module tb_bandit_environment;

  localparam int N = 5;
  // 0: default noisy, 1: noise off, 2/3: raw LFSR noise for saturation, 4: zero seed
  localparam logic [N-1:0] NE = 5'b11101;
  localparam int           SH [N] = '{4, 4, 0, 0, 0};
  localparam logic [15:0]  SD [N] = '{16'hACE1, 16'hACE1, 16'h7FFF, 16'h8000, 16'h0000};

  logic        clock;
  logic        rst [N];
  logic        av [N], ar [N], rv [N], rr [N], cv [N], cr [N];
  logic [7:0]  ad [N], ca [N];
  logic [15:0] rd [N], cd [N];
  logic [31:0] pl [N];

  int tests = 0;
  int fails = 0;

  // reference model for instance 0
  int          m_mean [256];
  logic [15:0] m_lfsr;
  int          m_pulls;

  for (genvar g = 0; g < N; g++) begin : g_dut
    bandit_environment #(.NOISE_ENABLE(NE[g]), .NOISE_SHIFT(SH[g]), .SEED(SD[g])) u_dut (
      .clock(clock), .reset(rst[g]),
      .action_valid(av[g]), .action_data(ad[g]), .action_ready(ar[g]),
      .reward_valid(rv[g]), .reward_data(rd[g]), .reward_ready(rr[g]),
      .cfg_valid(cv[g]), .cfg_addr(ca[g]), .cfg_data(cd[g]), .cfg_ready(cr[g]),
      .pulls(pl[g]));
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [15:0] m_step(input logic [15:0] x);
    return (x >> 1) ^ ((x % 2) ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [15:0] m_expect(input int mean, input logic [15:0] l);
    shortint s;
    int      v;
    s = l;
    v = mean + (s >>> 4);
    if (v > 32767)  v = 32767;
    if (v < -32768) v = -32768;
    return v[15:0];
  endfunction

  task automatic cfg_write(input int k, input logic [7:0] a, input logic [15:0] d);
    @(negedge clock); cv[k] = 1'b1; ca[k] = a; cd[k] = d;
    @(posedge clock); #1; cv[k] = 1'b0;
  endtask

  // Sends one action, returns reward and edges-from-accept until reward_valid.
  task automatic send(input int k, input logic [7:0] a, input int hold,
                      output logic [15:0] r, output int lat);
    @(negedge clock); av[k] = 1'b1; ad[k] = a;
    @(posedge clock); #1; av[k] = 1'b0;
    lat = 0;
    while (!rv[k] && lat < 20) begin @(posedge clock); #1; lat++; end
    r = rd[k];
    repeat (hold) @(posedge clock);
    @(negedge clock); rr[k] = 1'b1;
    @(posedge clock); #1; rr[k] = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clock);
    for (int k = 0; k < N; k++) rst[k] = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    for (int k = 0; k < N; k++) rst[k] = 1'b0;
    for (int k = 0; k < N; k++) begin
      tests++;
      if (ar[k] !== 1'b1 || cr[k] !== 1'b1 || rv[k] !== 1'b0 || rd[k] !== 16'h0 || pl[k] !== 32'd0) begin
        fails++;
        $display("FAIL reset[%0d]: ar=%b cr=%b rv=%b rd=%h pulls=%0d, want 1 1 0 0000 0", k, ar[k], cr[k], rv[k], rd[k], pl[k]);
      end
    end
  endtask

  task automatic test_basic;
    logic [15:0] r; int lat;
    cfg_write(1, 8'd5, 16'd1000);
    send(1, 8'd5, 0, r, lat);
    tests++;
    if (lat !== 2) begin fails++; $display("FAIL basic_latency: got %0d want 2", lat); end
    tests++;
    if (r !== 16'd1000) begin fails++; $display("FAIL basic_reward: got %0d want 1000", $signed(r)); end
    tests++;
    if (pl[1] !== 32'd1) begin fails++; $display("FAIL basic_pulls: got %0d want 1", pl[1]); end
  endtask

  task automatic test_saturation;
    logic [15:0] r; int lat;
    cfg_write(2, 8'd7, 16'h7FFF);
    send(2, 8'd7, 0, r, lat);
    tests++;
    if (r !== 16'h7FFF) begin fails++; $display("FAIL sat_pos: got %h want 7fff", r); end
    cfg_write(3, 8'd7, 16'h8000);
    send(3, 8'd7, 0, r, lat);
    tests++;
    if (r !== 16'h8000) begin fails++; $display("FAIL sat_neg: got %h want 8000", r); end
  endtask

  task automatic test_lfsr;
    logic [15:0] r; int lat;
    // mean 0 and shift 0 expose the captured LFSR value directly
    send(4, 8'd0, 0, r, lat);
    tests++;
    if (r !== 16'h0001) begin fails++; $display("FAIL lfsr_zero_seed: got %h want 0001", r); end
    repeat (7) @(posedge clock);
    send(4, 8'd0, 0, r, lat);
    tests++;
    if (r !== 16'hB400) begin fails++; $display("FAIL lfsr_step_from_1: got %h want b400", r); end
    // instance 0: ACE1 >>> 4 = FACE, then E270 >>> 4 = FE27
    send(0, 8'd9, 0, r, lat);
    tests++;
    if (r !== 16'hFACE) begin fails++; $display("FAIL lfsr_seed_noise: got %h want face", r); end
    repeat (5) @(posedge clock);
    send(0, 8'd9, 0, r, lat);
    tests++;
    if (r !== 16'hFE27) begin fails++; $display("FAIL lfsr_after_e270: got %h want fe27", r); end
    m_lfsr  = m_step(m_step(16'hACE1));
    m_pulls = 2;
  endtask

  task automatic test_backpressure;
    logic [15:0] r; int lat;
    cfg_write(1, 8'd10, 16'd555);
    cfg_write(1, 8'd11, 16'd77);
    @(negedge clock); av[1] = 1'b1; ad[1] = 8'd10;
    @(posedge clock); #1; av[1] = 1'b0;
    lat = 0;
    while (!rv[1] && lat < 20) begin @(posedge clock); #1; lat++; end
    tests++;
    if (lat >= 20) begin fails++; $display("FAIL bp_timeout: reward_valid never rose"); end
    @(negedge clock); cv[1] = 1'b1; ca[1] = 8'd11; cd[1] = 16'd9999;
    for (int c = 0; c < 5; c++) begin
      @(posedge clock); #1;
      tests++;
      if (rv[1] !== 1'b1 || rd[1] !== 16'd555 || ar[1] !== 1'b0 || cr[1] !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold[%0d]: rv=%b rd=%0d ar=%b cr=%b, want 1 555 0 0", c, rv[1], rd[1], ar[1], cr[1]);
      end
    end
    @(negedge clock); cv[1] = 1'b0; rr[1] = 1'b1;
    @(posedge clock); #1; rr[1] = 1'b0;
    tests++;
    if (rv[1] !== 1'b0 || pl[1] !== 32'd2) begin fails++; $display("FAIL bp_release: rv=%b pulls=%0d want 0 2", rv[1], pl[1]); end
    send(1, 8'd11, 0, r, lat);
    tests++;
    if (r !== 16'd77) begin fails++; $display("FAIL bp_cfg_blocked: got %0d want 77", $signed(r)); end
  endtask

  task automatic test_same_cycle;
    int lat;
    @(negedge clock);
    cv[1] = 1'b1; ca[1] = 8'd3; cd[1] = 16'hFF38;
    av[1] = 1'b1; ad[1] = 8'd3;
    @(posedge clock); #1; cv[1] = 1'b0; av[1] = 1'b0;
    lat = 0;
    while (!rv[1] && lat < 20) begin @(posedge clock); #1; lat++; end
    tests++;
    if (rd[1] !== 16'hFF38 || lat !== 2) begin
      fails++; $display("FAIL same_cycle: got %0d lat %0d want -200 lat 2", $signed(rd[1]), lat);
    end
    @(negedge clock); rr[1] = 1'b1;
    @(posedge clock); #1; rr[1] = 1'b0;
  endtask

  task automatic test_random;
    logic [15:0] r, exp_r, v; int lat; logic [7:0] a;
    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        a = 8'($urandom_range(0, 15));
        case ($urandom_range(0, 3))
          0:       v = 16'h7FFF;
          1:       v = 16'h8000;
          default: v = 16'($urandom);
        endcase
        cfg_write(0, a, v);
        m_mean[a] = $signed(v);
      end
      a = 8'($urandom_range(0, 15));
      exp_r  = m_expect(m_mean[a], m_lfsr);
      m_lfsr = m_step(m_lfsr);
      send(0, a, $urandom_range(0, 3), r, lat);
      m_pulls++;
      tests++;
      if (r !== exp_r || lat !== 2) begin
        fails++; $display("FAIL random[%0d] arm %0d: got %h lat %0d want %h lat 2", it, a, r, lat, exp_r);
      end
      tests++;
      if (pl[0] !== 32'(m_pulls)) begin fails++; $display("FAIL random_pulls[%0d]: got %0d want %0d", it, pl[0], m_pulls); end
      repeat ($urandom_range(0, 3)) @(posedge clock);
    end
  endtask

  task automatic test_reset_mid;
    logic [15:0] r, exp_r; int lat;
    cfg_write(0, 8'd20, 16'd100);
    m_mean[20] = 100;
    @(negedge clock); av[0] = 1'b1; ad[0] = 8'd20;
    @(posedge clock); #1; av[0] = 1'b0;
    @(posedge clock); #1;
    @(negedge clock); rst[0] = 1'b1;
    @(posedge clock); #1; rst[0] = 1'b0;
    tests++;
    if (rv[0] !== 1'b0 || ar[0] !== 1'b1 || pl[0] !== 32'd0 || rd[0] !== 16'h0) begin
      fails++; $display("FAIL reset_mid: rv=%b ar=%b pulls=%0d rd=%h want 0 1 0 0000", rv[0], ar[0], pl[0], rd[0]);
    end
    repeat (3) @(posedge clock);
    #1;
    tests++;
    if (rv[0] !== 1'b0) begin fails++; $display("FAIL reset_mid_discard: rv=%b want 0", rv[0]); end
    m_lfsr  = 16'hACE1;
    m_pulls = 0;
    exp_r   = m_expect(m_mean[20], m_lfsr);
    send(0, 8'd20, 0, r, lat);
    tests++;
    if (r !== exp_r) begin fails++; $display("FAIL reset_mid_table: got %h want %h", r, exp_r); end
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      rst[k] = 1'b1; av[k] = 1'b0; rr[k] = 1'b0; cv[k] = 1'b0;
      ad[k] = 8'd0; ca[k] = 8'd0; cd[k] = 16'd0;
    end
    for (int i = 0; i < 256; i++) m_mean[i] = 0;
    m_lfsr = 16'hACE1;
    m_pulls = 0;
    test_reset();
    test_basic();
    test_saturation();
    test_lfsr();
    test_backpressure();
    test_same_cycle();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
